// File: rtl/vga_timing_pkg.sv
//==============================================================================
// Module : vga_timing_pkg
// Brief  : Default 640x480@60 geometry, timing-mode type and sync-window helpers.
// Rev    : 1.0 - initial parametrised release
//==============================================================================
`default_nettype none

package vga_timing_pkg;

  localparam int CNT_W_DEF    = 10;
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  typedef struct packed {
    logic [15:0] h_active;
    logic [15:0] h_fp;
    logic [15:0] h_sync;
    logic [15:0] h_bp;
    logic [15:0] v_active;
    logic [15:0] v_fp;
    logic [15:0] v_sync;
    logic [15:0] v_bp;
  } timing_mode_t;

  localparam timing_mode_t MODE_640X480 = '{
    h_active: 16'(H_ACTIVE_DEF), h_fp: 16'(H_FP_DEF),
    h_sync:   16'(H_SYNC_DEF),   h_bp: 16'(H_BP_DEF),
    v_active: 16'(V_ACTIVE_DEF), v_fp: 16'(V_FP_DEF),
    v_sync:   16'(V_SYNC_DEF),   v_bp: 16'(V_BP_DEF)
  };

  // Sync window is [start, end) in counter units.
  function automatic int sync_start(input int active, input int fp);
    return active + fp;
  endfunction

  function automatic int sync_end(input int active, input int fp, input int sync);
    return active + fp + sync;
  endfunction

  localparam int H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
  localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;
  localparam int V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
  localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;

endpackage

`default_nettype wire

// File: rtl/vga_axis_counter.sv
//==============================================================================
// Module : vga_axis_counter
// Brief  : One raster axis: wrapping counter, wrap/active flags, registered sync.
// Rev    : 1.0 - initial parametrised release
//==============================================================================
`default_nettype none

module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int TOTAL      = H_TOTAL_DEF,
  parameter int ACTIVE     = H_ACTIVE_DEF,
  parameter int SYNC_START = H_SYNC_START_DEF,
  parameter int SYNC_END   = H_SYNC_END_DEF,
  parameter bit POL        = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sample,
  input  logic             advance,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             sync,
  output logic             active
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] ACT  = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SS   = CNT_W'(SYNC_START);
  localparam logic [CNT_W-1:0] SE   = CNT_W'(SYNC_END);

  logic in_sync;

  assign wrap    = (count == LAST);
  assign active  = (count < ACT);
  assign in_sync = (count >= SS) && (count < SE);

  // Sync is sampled from the pre-advance count, so it trails the counter by one tick.
  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
      sync  <= ~POL;
    end else begin
      if (sample)
        sync <= in_sync ? POL : ~POL;
      if (advance)
        count <= wrap ? '0 : count + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
//==============================================================================
// Module : vga_timing_gen
// Brief  : Parametrised VGA raster timing with divider, enable and strobes.
//          Optional VGA_TIMING_LOOKAHEAD_EN adds next_x/next_y prefetch outputs.
// Rev    : 1.0 - initial parametrised release
//==============================================================================
`default_nettype none

module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int CLK_DIV  = 1,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  output logic             pix_en,
  output logic [CNT_W-1:0] h_count,
  output logic [CNT_W-1:0] v_count,
  output logic             h_sync,
  output logic             v_sync,
  output logic             bright,
  output logic             line_start,
  output logic             frame_start
`ifdef VGA_TIMING_LOOKAHEAD_EN
  ,
  output logic [CNT_W-1:0] next_x,
  output logic [CNT_W-1:0] next_y
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;
  logic             tick;
  logic             h_wrap, v_wrap, h_active, v_active;

  assign tick = enable && (div == DIV_LAST);

  always_ff @(posedge clock) begin
    if (!reset)
      div <= '0;
    else if (enable)
      div <= tick ? '0 : div + DIV_W'(1);
  end

  vga_axis_counter #(
    .CNT_W(CNT_W), .TOTAL(H_TOTAL), .ACTIVE(H_ACTIVE),
    .SYNC_START(sync_start(H_ACTIVE, H_FP)),
    .SYNC_END(sync_end(H_ACTIVE, H_FP, H_SYNC)),
    .POL(H_POL)
  ) u_h_axis (
    .clock(clock), .reset(reset), .sample(tick), .advance(tick),
    .count(h_count), .wrap(h_wrap), .sync(h_sync), .active(h_active)
  );

  vga_axis_counter #(
    .CNT_W(CNT_W), .TOTAL(V_TOTAL), .ACTIVE(V_ACTIVE),
    .SYNC_START(sync_start(V_ACTIVE, V_FP)),
    .SYNC_END(sync_end(V_ACTIVE, V_FP, V_SYNC)),
    .POL(V_POL)
  ) u_v_axis (
    .clock(clock), .reset(reset), .sample(tick), .advance(tick && h_wrap),
    .count(v_count), .wrap(v_wrap), .sync(v_sync), .active(v_active)
  );

  // Strobes and pix_en drop to 0 on any edge without a tick, including while disabled.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pix_en      <= 1'b0;
      bright      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_en      <= tick;
      line_start  <= tick && h_wrap;
      frame_start <= tick && h_wrap && v_wrap;
      if (tick)
        bright <= h_active && v_active;
    end
  end

`ifdef VGA_TIMING_LOOKAHEAD_EN
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  // Runs one position ahead of the counters, so it wraps one tick earlier.
  always_ff @(posedge clock) begin
    if (!reset) begin
      next_x <= CNT_W'(1);
      next_y <= '0;
    end else if (tick) begin
      next_x <= (next_x == H_LAST) ? '0 : next_x + CNT_W'(1);
      if (next_x == H_LAST)
        next_y <= (next_y == V_LAST) ? '0 : next_y + CNT_W'(1);
    end
  end
`endif

endmodule

`default_nettype wire
